// File: rtl/iddr_deser.sv
// DDR input capture plus per-lane serial-to-parallel gearbox with a one-bit bitslip.
// Each lane emits a 2*RATIO-bit word every RATIO cycles; the LSB is the earliest bit.
module iddr_deser #(
    parameter int WIDTH = 1,
    parameter int RATIO = 4,
    localparam int WORD_W = 2 * RATIO,
    localparam int HIST_W = 4 * RATIO,
    localparam int OFF_W = $clog2(2 * RATIO)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          d,
    input  logic                      bitslip,
    output logic [WIDTH*WORD_W-1:0]   out_data,
    output logic                      out_valid,
    output logic                      slip_pending,
    output logic [OFF_W-1:0]          bit_offset
);

    logic [WIDTH-1:0]        rise_p0;
    logic [WIDTH-1:0]        fall_p0;
    logic [WIDTH-1:0]        rise_p1;
    logic [WIDTH-1:0]        fall_p1;
    logic [HIST_W-1:0]       hist_p2   [WIDTH];
    logic [HIST_W-1:0]       hist_next [WIDTH];
    logic [WIDTH*WORD_W-1:0] window;
    logic [3:0]              cnt;
    logic [4:0]              fill;
    logic                    suppress;
    logic                    fill_done;
    logic                    boundary;
    logic                    wrap;

    // Stage p0: raw pin samples on each edge
    always_ff @(posedge clk) begin
        rise_p0 <= d;
    end

    always_ff @(negedge clk) begin
        fall_p0 <= d;
    end

    // Stage p1: both samples retimed into the posedge domain
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_p1 <= '0;
            fall_p1 <= '0;
        end else begin
            rise_p1 <= rise_p0;
            fall_p1 <= fall_p0;
        end
    end

    // Stage p2: history shift (newest pair enters at the top) and word extraction
    always_comb begin
        hist_next = '{default: '0};
        window    = '0;
        for (int n = 0; n < WIDTH; n++) begin
            hist_next[n] = {fall_p1[n], rise_p1[n], hist_p2[n][HIST_W-1:2]};
            window[n*WORD_W +: WORD_W] = hist_next[n][bit_offset +: WORD_W];
        end
    end

    assign fill_done = (fill >= 5'(2 * RATIO - 1));
    assign boundary  = (cnt == 4'(RATIO - 1)) && fill_done;
    assign wrap      = slip_pending && (bit_offset == OFF_W'(2 * RATIO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_p2      <= '{default: '0};
            cnt          <= '0;
            fill         <= '0;
            suppress     <= 1'b0;
            out_data     <= '0;
            out_valid    <= 1'b0;
            slip_pending <= 1'b0;
            bit_offset   <= '0;
        end else begin
            hist_p2   <= hist_next;
            cnt       <= (cnt == 4'(RATIO - 1)) ? 4'd0 : cnt + 4'd1;
            out_valid <= boundary && !suppress;
            if (fill != 5'(2 * RATIO)) begin
                fill <= fill + 5'd1;
            end
            if (boundary && !suppress) begin
                out_data <= window;
            end
            // Offset moves only at word boundaries; a wrap back to 0 would repeat
            // almost a whole word, so the next boundary is skipped instead.
            if (boundary) begin
                suppress <= wrap;
                if (slip_pending) begin
                    bit_offset   <= wrap ? '0 : bit_offset + OFF_W'(1);
                    slip_pending <= 1'b0;
                end else begin
                    slip_pending <= bitslip;
                end
            end else if (bitslip) begin
                slip_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iddr_deser.sv
// Bench for iddr_deser: a WIDTH=1/RATIO=4 instance on a repeating 0xA5 stream and a
// WIDTH=2/RATIO=1 instance on constant lanes, both checked every cycle against a stream model.
module tb_iddr_deser;

    logic        clk;
    logic        rst;
    logic [0:0]  d_a;
    logic        bitslip_a;
    logic [7:0]  out_data_a;
    logic        out_valid_a;
    logic        slip_pending_a;
    logic [2:0]  bit_offset_a;
    logic [1:0]  d_b;
    logic        bitslip_b;
    logic [3:0]  out_data_b;
    logic        out_valid_b;
    logic        slip_pending_b;
    logic [0:0]  bit_offset_b;

    int checks;
    int failures;
    int ecnt;
    logic [7:0] pat;

    // model state, index 0 = instance a, 1 = instance b
    logic [1:0] rs [2][4096];
    logic [1:0] fs [2][4096];
    int         m_rl   [2];
    int         m_off  [2];
    bit         m_pend [2];
    bit         m_sup  [2];
    bit         m_val  [2];
    logic [7:0] m_word [2];

    iddr_deser #(.WIDTH(1), .RATIO(4)) dut_a (
        .clk(clk), .rst(rst), .d(d_a), .bitslip(bitslip_a),
        .out_data(out_data_a), .out_valid(out_valid_a),
        .slip_pending(slip_pending_a), .bit_offset(bit_offset_a)
    );

    iddr_deser #(.WIDTH(2), .RATIO(1)) dut_b (
        .clk(clk), .rst(rst), .d(d_b), .bitslip(bitslip_b),
        .out_data(out_data_b), .out_valid(out_valid_b),
        .slip_pending(slip_pending_b), .bit_offset(bit_offset_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Serial stream index idx: even = rise sample of edge idx/2, odd = fall sample.
    task automatic model_step(input int i, input int k, input logic r, input logic s);
        int R;
        int W;
        int p;
        int idx;
        logic [7:0] w;
        R = (i == 0) ? 4 : 1;
        W = (i == 0) ? 1 : 2;
        if (r) begin
            m_rl[i] = k; m_off[i] = 0; m_pend[i] = 0; m_sup[i] = 0;
            m_word[i] = '0; m_val[i] = 0;
            return;
        end
        p = k - m_rl[i];
        m_val[i] = 0;
        if (p >= 2 * R && p % R == 0) begin
            if (!m_sup[i]) begin
                w = '0;
                for (int n = 0; n < W; n++) begin
                    for (int j = 0; j < 2 * R; j++) begin
                        idx = 2 * k - 4 * R - 2 + m_off[i] + j;
                        if (idx >= 0 && idx / 2 >= m_rl[i])
                            w[n*2*R+j] = (idx % 2 == 1) ? fs[i][idx/2][n] : rs[i][idx/2][n];
                    end
                end
                m_word[i] = w;
                m_val[i] = 1;
            end
            m_sup[i] = 0;
            if (m_pend[i]) begin
                if (m_off[i] == 2 * R - 1) begin
                    m_sup[i] = 1;
                    m_off[i] = 0;
                end else begin
                    m_off[i] = m_off[i] + 1;
                end
                m_pend[i] = 0;
            end else begin
                m_pend[i] = s;
            end
        end else if (s) begin
            m_pend[i] = 1;
        end
    endtask

    // Stimulus: instance a carries pat LSB first; instance b lane0 rise=1/fall=0, lane1 the opposite.
    initial begin
        pat = 8'hA5;
        d_a = pat[2];
        d_b = 2'b01;
        forever begin
            @(posedge clk);
            #2;
            d_a = pat[(2 * ecnt + 1) % 8];
            d_b = 2'b10;
            @(negedge clk);
            #2;
            d_a = pat[(2 * (ecnt + 1)) % 8];
            d_b = 2'b01;
        end
    end

    always @(negedge clk) begin
        fs[0][ecnt] = {1'b0, d_a};
        fs[1][ecnt] = d_b;
    end

    always @(posedge clk) begin
        ecnt = ecnt + 1;
        if (ecnt >= 4000) begin
            $display("FAIL edge_budget: actual=%0d required<4000", ecnt);
            $fatal(1, "edge budget exhausted");
        end
        rs[0][ecnt] = {1'b0, d_a};
        rs[1][ecnt] = d_b;
        model_step(0, ecnt, rst, bitslip_a);
        model_step(1, ecnt, rst, bitslip_b);
        #1;
        check("a_out_valid", 32'(out_valid_a), 32'(m_val[0]));
        check("a_slip_pending", 32'(slip_pending_a), 32'(m_pend[0]));
        check("a_bit_offset", 32'(bit_offset_a), 32'(m_off[0]));
        check("a_out_data", 32'(out_data_a), 32'(m_word[0]));
        check("b_out_valid", 32'(out_valid_b), 32'(m_val[1]));
        check("b_slip_pending", 32'(slip_pending_b), 32'(m_pend[1]));
        check("b_bit_offset", 32'(bit_offset_b), 32'(m_off[1]));
        check("b_out_data", 32'(out_data_b), 32'(m_word[1][3:0]));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(output logic [7:0] w, output int gap);
        w = '0;
        gap = 0;
        while (gap < 40) begin
            step();
            gap++;
            if (out_valid_a === 1'b1) begin
                w = out_data_a;
                return;
            end
        end
        checks++;
        failures++;
        $display("FAIL wait_valid: actual=no out_valid in %0d cycles required=out_valid", gap);
    endtask

    task automatic pulse_a();
        bitslip_a = 1'b1;
        step();
        bitslip_a = 1'b0;
    endtask

    function automatic logic [7:0] rotr(input logic [7:0] v, input int n);
        logic [7:0] t;
        t = v;
        for (int i = 0; i < n; i++) t = {t[0], t[7:1]};
        return t;
    endfunction

    function automatic logic is_rot_a5(input logic [7:0] v);
        logic r;
        r = 1'b0;
        for (int i = 0; i < 8; i++) if (rotr(8'hA5, i) == v) r = 1'b1;
        return r;
    endfunction

    initial begin
        logic [7:0] w;
        logic [7:0] r0;
        int g;
        int first_a;
        int first_b;
        checks = 0;
        failures = 0;
        ecnt = 0;
        rst = 1'b1;
        bitslip_a = 1'b0;
        bitslip_b = 1'b0;
        step(); step(); step();
        check("reset_valid", 32'(out_valid_a), 32'd0);
        check("reset_data", 32'(out_data_a), 32'd0);
        rst = 1'b0;

        first_a = 0;
        first_b = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (first_b == 0 && out_valid_b === 1'b1) first_b = n;
            if (out_valid_a === 1'b1) begin
                first_a = n;
                break;
            end
        end
        check("first_valid_edge_a", 32'(first_a), 32'd8);
        check("first_valid_edge_b", 32'(first_b), 32'd2);
        check("first_word_a", 32'(out_data_a), 32'h58);
        check("b_word_lit", 32'(out_data_b), 32'b1001);

        // steady stream at offset 0
        wait_valid(r0, g);
        check("gap_steady", 32'(g), 32'd4);
        check("r0_lit", 32'(r0), 32'h5A);
        check("r0_is_rotation", 32'(is_rot_a5(r0)), 32'd1);
        wait_valid(w, g);
        check("word_constant", 32'(w), 32'(r0));
        check("offset0", 32'(bit_offset_a), 32'd0);

        // single slip
        pulse_a();
        check("pending_set", 32'(slip_pending_a), 32'd1);
        wait_valid(w, g);
        check("slip_word_old", 32'(w), 32'(r0));
        check("pending_clear", 32'(slip_pending_a), 32'd0);
        check("offset1", 32'(bit_offset_a), 32'd1);
        wait_valid(w, g);
        check("slip_word_new", 32'(w), 32'(rotr(r0, 1)));
        check("slip_word_lit", 32'(w), 32'h2D);

        // walk to offset 7, then wrap
        for (int o = 2; o <= 7; o++) begin
            pulse_a();
            wait_valid(w, g);
            check("offset_walk", 32'(bit_offset_a), 32'(o));
        end
        wait_valid(w, g);
        check("word_off7", 32'(w), 32'(rotr(r0, 7)));
        pulse_a();
        wait_valid(w, g);
        check("wrap_word_old", 32'(w), 32'(rotr(r0, 7)));
        check("wrap_offset", 32'(bit_offset_a), 32'd0);
        wait_valid(w, g);
        check("wrap_gap", 32'(g), 32'd8);
        check("wrap_word", 32'(w), 32'(r0));

        // second request while pending is dropped
        bitslip_a = 1'b1;
        step();
        bitslip_a = 1'b0;
        step();
        bitslip_a = 1'b1;
        step();
        bitslip_a = 1'b0;
        wait_valid(w, g);
        check("double_word_old", 32'(w), 32'(r0));
        check("double_pending", 32'(slip_pending_a), 32'd0);
        check("double_offset", 32'(bit_offset_a), 32'd1);
        wait_valid(w, g);
        check("double_word_new", 32'(w), 32'(rotr(r0, 1)));

        // reset mid-stream with a slip pending
        pulse_a();
        check("pre_reset_pending", 32'(slip_pending_a), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_reset_valid", 32'(out_valid_a), 32'd0);
        check("mid_reset_pending", 32'(slip_pending_a), 32'd0);
        check("mid_reset_offset", 32'(bit_offset_a), 32'd0);
        check("mid_reset_data", 32'(out_data_a), 32'd0);
        first_a = 0;
        for (int n = 1; n <= 20; n++) begin
            step();
            if (out_valid_a === 1'b1) begin
                first_a = n;
                break;
            end
        end
        check("rearm_valid_edge", 32'(first_a), 32'd8);

        // RATIO=1 instance slip
        check("b_word_pre_slip", 32'(out_data_b), 32'b1001);
        bitslip_b = 1'b1;
        step();
        bitslip_b = 1'b0;
        step();
        step();
        check("b_word_slipped", 32'(out_data_b), 32'b0110);
        check("b_offset", 32'(bit_offset_b), 32'd1);
        check("b_valid", 32'(out_valid_b), 32'd1);

        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: actual=still running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/iddr_deser.md
Name: iddr_deser

Overview:
- Generic-fabric DDR input capture followed by a per-lane serial-to-parallel gearbox with word-alignment bitslip.
- Captures WIDTH DDR lanes (rising-edge bit first, then falling-edge bit) and emits 2*RATIO-bit words per lane every RATIO cycles.
- Sits between source-synchronous pins (RGMII/SGMII-style, training-pattern links) and the framing logic, which drives bitslip until its pattern matches.

Parameters:
- WIDTH, 1, number of DDR lanes.
- RATIO, 4, DDR clock cycles per output word. Legal range 1..8. Each lane word is 2*RATIO bits.

Ports:
- clk  input  1  capture clock; both edges sample d.
- rst  input  1  reset, synchronous, active-high, posedge domain.
- d  input  WIDTH  DDR data lanes.
- bitslip  input  1  request a one-half-bit (one serial bit) alignment shift on all lanes.
- out_data  output  WIDTH*2*RATIO  lane n word at [n*2*RATIO +: 2*RATIO]; LSB is the earliest received bit.
- out_valid  output  1  one-cycle strobe; out_data is new this cycle.
- slip_pending  output  1  bitslip accepted, not yet applied.
- bit_offset  output  clog2(2*RATIO), min 1  current window offset.

Behaviour:
Capture:
- d_r is sampled at posedge; d_f is sampled at the following negedge. Both are retimed at the next posedge into q1 (rise) and q2 (fall).
- d_r and d_f are not reset. q1/q2 reset to 0.
- The rising sample at posedge e is in q1 after e+1 and pushed into history at e+2.

History:
- Per lane, hist is 4*RATIO bits, reset 0.
- Every non-reset cycle: hist <= {q2, q1, hist[4R-1:2]}. Oldest bit is at hist[0].

Counters:
- cnt counts 0..R-1, reset 0, increments every non-reset cycle and wraps.
- fill saturates at 2R pushes, reset 0.

Emission:
- An emit cycle is one where cnt==R-1, fill has reached 2R including this push, and suppress==0.
- On an emit cycle, out_data <= window, where window is hist_next[bit_offset +: 2R] (hist_next = value being loaded this edge). out_valid <= 1.
- out_valid is 0 in all other cycles. out_data holds its value between emits.
- First out_valid: at the 2R-th clk edge after rst deasserts.

Bitslip:
- If slip_pending==0 and bitslip==1: slip_pending <= 1.
- bitslip while slip_pending==1 is ignored. Requests do not queue.
- At the next boundary (cnt==R-1, fill done), whether emitted or suppressed:
  - that word uses the old offset;
  - then bit_offset <= (bit_offset+1) mod 2R and slip_pending <= 0.
- bitslip asserted in the same cycle as a boundary with slip_pending==0 only sets pending. It applies at the following boundary.
- Normal step: the next word starts 2R+1 serial bits after the previous one, so one bit is dropped.
- Wrap (2R-1 -> 0): suppress <= 1, and the next boundary emits nothing (out_valid stays 0). suppress clears at that boundary. This prevents 2R-1 duplicated bits; net effect is still a one-bit drop.
- A slip becoming due on the suppressed boundary is applied there. Its own wrap rules apply.

Reset:
- Reset values: out_data=0, out_valid=0, slip_pending=0, bit_offset=0. cnt, fill, suppress, hist, q1, q2 are also cleared.
- rst mid-stream: all state is cleared on that edge, any pending slip is discarded, and warm-up repeats in full after release.

Lanes:
- All lanes share cnt, offset and slip. Lanes never interact in data.
- RATIO=1: emit every cycle after fill; wrap occurs on every second slip.

Test Plan:
1. WIDTH=1, RATIO=4; d drives serial 0xA5 repeating (LSB first, rise then fall) -> out_valid exactly every 4 cycles from edge 8 after rst release. out_data constant, equal to some rotation R0 of 0xA5. bit_offset=0.
2. From test 1, one bitslip pulse -> slip_pending=1 until the next boundary. The word at that boundary equals R0. Subsequent words equal R0 rotated right by 1. bit_offset=1.
3. Slip repeatedly to bit_offset=7, then one more bitslip -> bit_offset=0, exactly one boundary without out_valid (gap of 8 cycles). The following word equals R0 rotated right by 8 = R0, with no repeated word.
4. Two bitslip pulses 1 cycle apart, both before one boundary -> second pulse ignored; bit_offset advances by exactly 1.
5. rst high for 1 cycle mid-stream with slip_pending=1 -> next cycle out_valid=0, slip_pending=0, bit_offset=0, out_data=0. First out_valid at edge 8 after release.
6. WIDTH=2, RATIO=1; lane0 constant rise=1/fall=0, lane1 rise=0/fall=1 -> out_valid every cycle from edge 2. out_data=4'b1001 (lane1=2'b10, lane0=2'b01). One bitslip -> 4'b0110.
